// File: rtl/booth_seq_mult.sv
// booth_seq_mult
//   Radix-2 Booth sequential multiplier with a start/busy/done handshake.
//   One operation is in flight at a time. The result appears WIDTH+1 cycles
//   after start is sampled. Signed and unsigned operands are both handled.
//
// Ports
//   clk       : system clock, rising-edge active
//   rst       : asynchronous, active-high reset
//   start     : request a new multiply; sampled only in IDLE
//   is_signed : 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   X         : multiplicand, WIDTH bits (sampled with start)
//   Y         : multiplier, WIDTH bits (sampled with start)
//   busy      : high while an operation is executing
//   done      : one-cycle pulse; Z holds a new result
//   Z         : 2*WIDTH-bit product, registered; held until the next result
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Z
);

  // Operands are widened by one bit so the unsigned range fits in a signed
  // representation; the accumulator gets one more bit so A-M cannot overflow
  // even for the most-negative operand.
  localparam int QW = WIDTH + 1;
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [QW-1:0]       m_r, m_s;
  logic [QW-1:0]       q_r, q_s;
  logic [AW-1:0]       a_r, a_s;
  logic                q1_r, q1_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [2*WIDTH-1:0]  z_r, z_s;
  logic                done_r, done_s;

  logic [AW-1:0]       m_ext_s;
  logic [AW-1:0]       sum_s;
  logic [AW-1:0]       a_sh_s;
  logic [QW-1:0]       q_sh_s;

  // Widen an operand by one bit: sign-extend in signed mode, zero-extend otherwise.
  function automatic logic [QW-1:0] ext_op(input logic [WIDTH-1:0] v, input logic sgn);
    ext_op = {sgn & v[WIDTH-1], v};
  endfunction

  // Booth add/subtract step followed by the arithmetic right shift of {A,Q,q_1}.
  always_comb begin
    m_ext_s = {m_r[QW-1], m_r};
    case ({q_r[0], q1_r})
      2'b01:   sum_s = a_r + m_ext_s;
      2'b10:   sum_s = a_r - m_ext_s;
      default: sum_s = a_r;
    endcase
    a_sh_s = {sum_s[AW-1], sum_s[AW-1:1]};
    q_sh_s = {sum_s[0], q_r[QW-1:1]};
  end

  // Next-state and datapath-register next values.
  always_comb begin
    state_s = state_r;
    m_s     = m_r;
    q_s     = q_r;
    a_s     = a_r;
    q1_s    = q1_r;
    cnt_s   = cnt_r;
    z_s     = z_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          m_s     = ext_op(X, is_signed);
          q_s     = ext_op(Y, is_signed);
          a_s     = '0;
          q1_s    = 1'b0;
          cnt_s   = CW'(WIDTH + 1);
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        a_s   = a_sh_s;
        q_s   = q_sh_s;
        q1_s  = q_r[0];
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          // Low 2*WIDTH bits of the shifted {A,Q}; the upper bits are pure sign.
          z_s     = {a_sh_s[WIDTH-2:0], q_sh_s};
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      m_r     <= '0;
      q_r     <= '0;
      a_r     <= '0;
      q1_r    <= 1'b0;
      cnt_r   <= '0;
      z_r     <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      m_r     <= m_s;
      q_r     <= q_s;
      a_r     <= a_s;
      q1_r    <= q1_s;
      cnt_r   <= cnt_s;
      z_r     <= z_s;
      done_r  <= done_s;
    end
  end

  assign busy = (state_r == RUN);
  assign done = done_r;
  assign Z    = z_r;

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult
//   Directed table of WIDTH=8 vectors, handshake/reset sequences, and random
//   WIDTH=16 operands checked against a behavioural multiply.
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sgn8;
  logic [7:0]  x8, y8;
  logic        busy8, done8;
  logic [15:0] z8;
  logic        start16, sgn16;
  logic [15:0] x16, y16;
  logic        busy16, done16;
  logic [31:0] z16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .X(x8), .Y(y8), .busy(busy8), .done(done8), .Z(z8)
  );

  booth_seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .is_signed(sgn16),
    .X(x16), .Y(y16), .busy(busy16), .done(done16), .Z(z16)
  );

  typedef struct {
    logic        sgn;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge. Drives the operands, lets the next
  // rising edge sample them, then scrambles inputs while busy. When poke>=0,
  // start is re-asserted with other operands at that cycle. Returns at the
  // falling edge where done is seen (or after the cycle budget).
  task automatic issue8(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input int poke, output logic [15:0] zo, output int lat,
                        output logic busy_at1, output logic done_after_k);
    start8 = 1'b1; sgn8 = s; x8 = x; y8 = y;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    done_after_k = done8;
    busy_at1 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      if (lat == 1) busy_at1 = busy8;
      x8 = ~x; y8 = y ^ 8'h5A; sgn8 = ~s;
      start8 = (lat == poke);
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    zo = z8;
  endtask

  task automatic issue16(input logic s, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] zo, output int lat);
    @(negedge clk);
    start16 = 1'b1; sgn16 = s; x16 = x; y16 = y;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 60) begin
      x16 = ~x; y16 = ~y;
      @(negedge clk);
      lat++;
    end
    zo = z16;
  endtask

  // Counts done pulses over n cycles.
  task automatic count_done8(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
  endtask

  initial begin
    logic [15:0] zo;
    logic [31:0] zo16, e16;
    logic        b1, dk;
    logic        s;
    logic [15:0] rx, ry;
    longint      ex, ey;
    int          lat, cnt;

    vt[0]  = '{1'b1, 8'h04, 8'hFE, 16'hFFF8};
    vt[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vt[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vt[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vt[4]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vt[5]  = '{1'b1, 8'h00, 8'hFF, 16'h0000};
    vt[6]  = '{1'b1, 8'h03, 8'h05, 16'h000F};
    vt[7]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vt[8]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    vt[9]  = '{1'b0, 8'h12, 8'h34, 16'h03A8};
    vt[10] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vt[11] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81};
    vt[12] = '{1'b1, 8'h80, 8'hFF, 16'h0080};
    vt[13] = '{1'b0, 8'h01, 8'hFF, 16'h00FF};

    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
    start16 = 1'b0; sgn16 = 1'b0; x16 = 16'h0000; y16 = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy8}, 32'd0);
    check("reset done", {31'd0, done8}, 32'd0);
    check("reset Z", {16'd0, z8}, 32'd0);
    check("reset Z16", z16, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      issue8(vt[i].sgn, vt[i].x, vt[i].y, -1, zo, lat, b1, dk);
      check($sformatf("vec%0d Z", i), {16'd0, zo}, {16'd0, vt[i].z});
      check($sformatf("vec%0d latency", i), lat, 32'd9);
      check($sformatf("vec%0d busy mid", i), {31'd0, b1}, 32'd1);
      check($sformatf("vec%0d busy at done", i), {31'd0, busy8}, 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d done width", i), {31'd0, done8}, 32'd0);
      check($sformatf("vec%0d Z hold", i), {16'd0, z8}, {16'd0, vt[i].z});
    end

    // Start while busy is ignored
    issue8(1'b1, 8'h04, 8'hFE, 3, zo, lat, b1, dk);
    check("busy start Z", {16'd0, zo}, 32'h0000FFF8);
    check("busy start latency", lat, 32'd9);
    count_done8(12, cnt);
    check("busy start no extra done", cnt, 32'd0);

    // Back-to-back: issue again in the done cycle
    @(negedge clk);
    issue8(1'b0, 8'hFF, 8'hFF, -1, zo, lat, b1, dk);
    check("b2b first Z", {16'd0, zo}, 32'h0000FE01);
    issue8(1'b1, 8'h03, 8'h05, -1, zo, lat, b1, dk);
    check("b2b done cleared", {31'd0, dk}, 32'd0);
    check("b2b second Z", {16'd0, zo}, 32'h0000000F);
    check("b2b second latency", lat, 32'd9);

    // Reset mid-operation
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b1; x8 = 8'h7F; y8 = 8'h7F;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy8}, 32'd0);
    check("abort done", {31'd0, done8}, 32'd0);
    check("abort Z", {16'd0, z8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done8(15, cnt);
    check("abort no done", cnt, 32'd0);
    issue8(1'b1, 8'h03, 8'h05, -1, zo, lat, b1, dk);
    check("after abort Z", {16'd0, zo}, 32'h0000000F);
    check("after abort latency", lat, 32'd9);

    // WIDTH=16 random operands in both modes
    for (int i = 0; i < 1500; i++) begin
      s = i[0];
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i < 4) begin
        rx = 16'h8000;
        ry = (i < 2) ? 16'h8000 : 16'h7FFF;
      end
      ex = s ? longint'($signed(rx)) : longint'(rx);
      ey = s ? longint'($signed(ry)) : longint'(ry);
      e16 = 32'(ex * ey);
      issue16(s, rx, ry, zo16, lat);
      check($sformatf("w16 #%0d s=%0d %0h*%0h", i, s, rx, ry), zo16, e16);
      check($sformatf("w16 #%0d latency", i), lat, 32'd17);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
